pulse_capture: RTL and testbench
================================

# pulse_capture

Input-capture peripheral: measures the period and high time of an external digital signal in units of a prescaled clock. It synchronises the input, detects edges and times them with an internal saturating cycle counter. Each completed measurement is published to a register interface with a valid/ack handshake. It sits beside the free-running timers in the peripheral subsystem and is the measuring counterpart of the counter/PWM timebase: it consumes waveforms rather than generating them.

## Interface
- WIDTH, 16, width of period and high_time outputs
- DIV, 0, prescale bits; outputs equal elapsed clk cycles >> DIV
- SYNC_STAGES, 2, input synchroniser depth (min 2)
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  measurement enable; low forces IDLE
- signal_in  input  1  asynchronous measured signal
- ack  input  1  consumer acknowledge of current result
- clear  input  1  clears sticky flags missed and overflow
- period  output  WIDTH  rising-to-rising time of last published measurement
- high_time  output  WIDTH  rising-to-falling time of same measurement
- valid  output  1  result pending; held until ack
- missed  output  1  sticky: a measurement completed while valid was held and was dropped
- overflow  output  1  sticky: counter saturated before the awaited edge

## Operation
- signal_in passes through SYNC_STAGES flops, then one flop for edge detect; rise/fall are single-cycle pulses.
- Raw counter: WIDTH+DIV bits. It is cleared to 1 in the rise-detect cycle, increments every cycle after, and saturates at all-ones. Captured value = raw[WIDTH+DIV-1:DIV] in the detect cycle, before clearing.
- FSM states:
  - IDLE: enable=0, counter held at 0. enable=1 -> ARM.
  - ARM: waiting for first rise. rise -> HIGH, counter starts.
  - HIGH: fall -> latch hold_high <= captured value, -> LOW.
  - LOW: rise -> publish, counter restarts, -> HIGH.
  - Any state with enable=0 -> IDLE.
- Saturation in HIGH or LOW: overflow <= 1, -> ARM, nothing published.
- Publish: period <= captured, high_time <= hold_high, valid <= 1. This happens only if valid=0 or ack=1 in the same cycle.
- Publish with valid=1 and ack=0: outputs unchanged, missed <= 1.
- ack with valid=1 and no publish: valid <= 0. ack with valid=0 is ignored.
- clear zeroes missed and overflow. A set event in the same cycle wins.
- Deasserting enable does not clear valid, period, high_time or the flags.
- Reset: all outputs 0, FSM IDLE, counter 0, synchroniser flops 0.

## Timing
- signal_in edge to rise/fall pulse: SYNC_STAGES+1 clk cycles.
- Rise pulse to valid/period/high_time update: 1 cycle (registered).
- With DIV=0, period = exact clk cycles between rising edges; high_time = clk cycles rise to fall. Equal synchroniser delay on both edges cancels.
- Minimum measurable pulse width is 1 cycle of synchronised signal. Narrower glitches may be lost; no error is flagged.
- Back-to-back results every period. Consumer must ack within one period or lose data (missed).

## Structure
- Shared package/header: FSM state encodings (IDLE, ARM, HIGH, LOW, 2 bits) and the SYNC_STAGES minimum constant.
- Sub-module edge_sync: synchroniser chain plus edge detector. Parameter SYNC_STAGES; ports clk, rst_n, d, level, rise, fall. Reused by other input peripherals.
- FSM, counter, capture registers and handshake live in pulse_capture.

## Test plan
- Square wave, DIV=0, period 10, high 4, enable=1, ack each result. Result: first valid SYNC_STAGES+2 cycles after second rising input edge; period=10, high_time=4; missed=0, overflow=0.
- DIV=2, period 40, high 12. Result: period=10, high_time=3.
- No ack for three periods of a 20/7 wave. Result: valid stays 1; outputs hold first result (20, 7); missed=1. ack then clear: valid=0, missed=0.
- WIDTH=4, DIV=0, input held high for 20 cycles after a rise. Result: overflow=1 at raw count 15, FSM in ARM, no valid. The next two rises yield a normal result.
- ack asserted in the same cycle as a new publish. Result: new values load, valid stays 1, missed stays 0.
- rst_n dropped mid-HIGH, asynchronously. Result: all outputs 0 immediately. After release, the first rise is treated as ARM; no result until the second rise.
- enable dropped mid-LOW. Result: IDLE, previous valid result retained. Re-enable requires two rises before the next publish.

Source files
------------

// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the input-capture peripheral.
// No logic: FSM state encodings and synchroniser depth floor.
// No handshake.
package pulse_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous level and emits single-cycle rise/fall pulses.
// Latency: input edge to rise/fall pulse is SYNC_STAGES+1 clk cycles.
// No backpressure; pulses are dropped if the consumer ignores them.
module edge_sync
    import pulse_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    // Depths below the metastability floor are silently raised to it.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d};
            level_q <= sync_q[STAGES-1];
            rise    <= sync_q[STAGES-1] & ~level_q;
            fall    <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/pulse_capture.sv
// Measures period and high time of signal_in in clk>>DIV units.
// Latency: result registered 1 cycle after the synchronised rise pulse.
// valid held until ack; a result arriving while held is dropped and flagged missed.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIV         = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             signal_in,
    input  logic             ack,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             missed,
    output logic             overflow
);

    localparam int CW = WIDTH + DIV;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_high;
    logic [WIDTH-1:0] captured;
    logic             level_unused;
    logic             rise;
    logic             fall;
    logic             sat;
    logic             pub;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal_in),
        .level (level_unused),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturation beats a coincident edge: the true interval is unknown.
    always_comb begin
        captured = cnt[CW-1:DIV];
        sat      = enable && ((state == ST_HIGH) || (state == ST_LOW)) && (cnt == '1);
        pub      = enable && (state == ST_LOW) && rise && !sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hold_high <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            missed    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (!enable || (state == ST_IDLE)) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= CW'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + CW'(1);
            end

            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ARM;
                    ST_ARM:  if (rise) state <= ST_HIGH;
                    ST_HIGH: begin
                        if (sat) begin
                            state <= ST_ARM;
                        end else if (fall) begin
                            hold_high <= captured;
                            state     <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (sat) begin
                            state <= ST_ARM;
                        end else if (rise) begin
                            state <= ST_HIGH;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (pub) begin
                if (!valid || ack) begin
                    period    <= captured;
                    high_time <= hold_high;
                    valid     <= 1'b1;
                end
            end else if (ack) begin
                valid <= 1'b0;
            end

            // Sticky flags: a set event in the same cycle as clear wins.
            if (pub && valid && !ack) begin
                missed <= 1'b1;
            end else if (clear) begin
                missed <= 1'b0;
            end

            if (sat) begin
                overflow <= 1'b1;
            end else if (clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: DIV=0, DIV=2 and WIDTH=4 instances on shared stimulus.
// Vector table for steady square waves, hand sequences for handshake, overflow, reset, enable.
// Outputs sampled #1 after posedge or on negedge.
module tb_pulse_capture;
    import pulse_capture_pkg::*;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic enable    = 1'b0;
    logic signal_in = 1'b0;
    logic ack       = 1'b0;
    logic clear     = 1'b0;

    logic [15:0] period0, high0, period2, high2;
    logic [3:0]  period4, high4;
    logic        valid0, missed0, ovf0;
    logic        valid2, missed2, ovf2;
    logic        valid4, missed4, ovf4;

    int cyc       = 0;
    int rise2_cyc = 0;
    int total     = 0;
    int bad       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_capture #(.WIDTH(16), .DIV(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in), .ack(ack), .clear(clear),
        .period(period0), .high_time(high0), .valid(valid0), .missed(missed0), .overflow(ovf0));

    pulse_capture #(.WIDTH(16), .DIV(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in), .ack(ack), .clear(clear),
        .period(period2), .high_time(high2), .valid(valid2), .missed(missed2), .overflow(ovf2));

    pulse_capture #(.WIDTH(4), .DIV(0), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in), .ack(ack), .clear(clear),
        .period(period4), .high_time(high4), .valid(valid4), .missed(missed4), .overflow(ovf4));

    typedef struct {
        int hi;
        int per;
        int p0;
        int h0;
        int p2;
        int h2;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prep();
        enable    = 1'b0;
        signal_in = 1'b0;
        ack       = 1'b1;
        clear     = 1'b1;
        step(1);
        ack   = 1'b0;
        clear = 1'b0;
        step(5);
        enable = 1'b1;
        step(3);
    endtask

    task automatic gen_wave(input int hi, input int per, input int nper);
        signal_in = 1'b0;
        step(4);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < per; c++) begin
                signal_in = (c < hi);
                if (c == 0 && p == 1) rise2_cyc = cyc;
                step(1);
            end
        end
        signal_in = 1'b0;
    endtask

    task automatic wait_check(input int i);
        int n = 0;
        @(negedge clk);
        while (valid0 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_valid", i), int'(valid0), 1);
        chk($sformatf("v%0d_latency", i), cyc - rise2_cyc, 4);
        chk($sformatf("v%0d_period_div0", i), int'(period0), vecs[i].p0);
        chk($sformatf("v%0d_high_div0", i), int'(high0), vecs[i].h0);
        chk($sformatf("v%0d_period_div2", i), int'(period2), vecs[i].p2);
        chk($sformatf("v%0d_high_div2", i), int'(high2), vecs[i].h2);
        ack = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{hi: 4,  per: 10, p0: 10, h0: 4,  p2: 2,  h2: 1};
        vecs[1] = '{hi: 12, per: 40, p0: 40, h0: 12, p2: 10, h2: 3};
        vecs[2] = '{hi: 3,  per: 7,  p0: 7,  h0: 3,  p2: 1,  h2: 0};
        vecs[3] = '{hi: 1,  per: 25, p0: 25, h0: 1,  p2: 6,  h2: 0};

        // Reset state
        step(2);
        chk("rst_period", int'(period0), 0);
        chk("rst_high", int'(high0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_missed", int'(missed0), 0);
        chk("rst_overflow", int'(ovf0), 0);
        chk("rst_state", int'(dut0.state), int'(ST_IDLE));
        rst_n = 1'b1;
        step(2);

        // Steady square waves, acked each result
        for (int i = 0; i < 4; i++) begin
            prep();
            fork
                gen_wave(vecs[i].hi, vecs[i].per, 3);
                wait_check(i);
            join
            step(6);
            chk($sformatf("v%0d_missed", i), int'(missed0), 0);
            chk($sformatf("v%0d_overflow", i), int'(ovf0), 0);
            ack = 1'b0;
        end

        // ack in the same cycle as a new publish
        prep();
        signal_in = 1'b1; step(4);
        signal_in = 1'b0; step(6);
        signal_in = 1'b1; step(5);
        signal_in = 1'b0; step(7);
        signal_in = 1'b1; step(3);
        chk("ackpub_pre_valid", int'(valid0), 1);
        chk("ackpub_pre_period", int'(period0), 10);
        chk("ackpub_pre_high", int'(high0), 4);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ackpub_valid", int'(valid0), 1);
        chk("ackpub_period", int'(period0), 12);
        chk("ackpub_high", int'(high0), 5);
        chk("ackpub_missed", int'(missed0), 0);
        signal_in = 1'b0; step(3);

        // No ack for three results of a 20/7 wave
        prep();
        gen_wave(7, 20, 4);
        step(6);
        chk("noack_valid", int'(valid0), 1);
        chk("noack_period", int'(period0), 20);
        chk("noack_high", int'(high0), 7);
        chk("noack_missed", int'(missed0), 1);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("noack_acked_valid", int'(valid0), 0);
        chk("noack_acked_missed", int'(missed0), 1);
        clear = 1'b1; step(1); clear = 1'b0;
        chk("noack_cleared_missed", int'(missed0), 0);

        // WIDTH=4 saturation while high
        prep();
        signal_in = 1'b1; step(18);
        chk("sat_before", int'(ovf4), 0);
        step(1);
        chk("sat_overflow", int'(ovf4), 1);
        chk("sat_state_arm", int'(dut4.state), int'(ST_ARM));
        step(1);
        signal_in = 1'b0; step(6);
        chk("sat_no_valid", int'(valid4), 0);
        gen_wave(4, 10, 2);
        step(6);
        chk("sat_next_valid", int'(valid4), 1);
        chk("sat_next_period", int'(period4), 10);
        chk("sat_next_high", int'(high4), 4);
        chk("sat_sticky", int'(ovf4), 1);

        // Asynchronous reset mid-HIGH
        prep();
        signal_in = 1'b1; step(4);
        signal_in = 1'b0; step(6);
        signal_in = 1'b1; step(6);
        chk("arst_pre_valid", int'(valid0), 1);
        chk("arst_pre_period", int'(period0), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_period", int'(period0), 0);
        chk("arst_high", int'(high0), 0);
        chk("arst_valid", int'(valid0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(3);
        signal_in = 1'b0; step(7);
        chk("arst_first_rise_arms", int'(valid0), 0);
        signal_in = 1'b1; step(6);
        chk("arst_after_valid", int'(valid0), 1);
        chk("arst_after_period", int'(period0), 10);
        chk("arst_after_high", int'(high0), 3);

        // enable dropped mid-LOW
        signal_in = 1'b0; step(6);
        enable = 1'b0; step(2);
        chk("dis_state", int'(dut0.state), int'(ST_IDLE));
        chk("dis_valid_kept", int'(valid0), 1);
        chk("dis_period_kept", int'(period0), 10);
        chk("dis_high_kept", int'(high0), 3);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("dis_acked", int'(valid0), 0);
        enable = 1'b1; step(2);
        signal_in = 1'b1; step(5);
        signal_in = 1'b0; step(7);
        chk("reen_first_rise", int'(valid0), 0);
        signal_in = 1'b1; step(6);
        chk("reen_valid", int'(valid0), 1);
        chk("reen_period", int'(period0), 12);
        chk("reen_high", int'(high0), 5);
        chk("reen_missed", int'(missed0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
